// File: rtl/xs_seq_tx.sv
// Purpose : serial pattern transmitter; latches a parallel pattern on start and shifts it out MSB-first on xs.
// Latency : first bit on xs the cycle after start is sampled; done pulses one cycle after the last bit/gap.
// Backpressure: none; start is only honoured in IDLE, requests while busy or in DONE are dropped.
// Option  : define XS_TX_PARITY_EN to append an even-parity bit after every repetition.
module xs_seq_tx #(
    parameter int W    = 8,
    parameter int LENW = 4,
    parameter int REPW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [W-1:0]    pattern,
    input  logic [LENW-1:0] len,
    input  logic [REPW-1:0] reps,
    output logic            xs,
    output logic            busy,
    output logic            done
);

`ifdef XS_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_PAR, S_GAP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_pat;
    logic [W-1:0]    w_pat_nxt;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] w_len_nxt;
    logic [REPW-1:0] r_reps;
    logic [REPW-1:0] w_reps_nxt;
    logic [LENW-1:0] r_idx;
    logic [LENW-1:0] w_idx_nxt;
    logic            r_par;
    logic            w_par_nxt;
    logic            r_xs;
    logic            r_busy;
    logic            r_done;
    logic            w_xs_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    logic [LENW-1:0] w_len_clamp;
    logic [W-1:0]    w_cur_sh;
    logic [W-1:0]    w_nxt_sh;
    logic            w_cur_bit;

    // Lengths beyond the pattern width are treated as the full width.
    assign w_len_clamp = (len > LENW'(W)) ? LENW'(W) : len;
    // Shifts instead of variable part-selects keep the index width independent of W.
    assign w_cur_sh    = r_pat >> r_idx;
    assign w_cur_bit   = w_cur_sh[0];
    assign w_nxt_sh    = w_pat_nxt >> w_idx_nxt;

    // Next-state logic; r_par accumulates the XOR of bits sent in the current repetition.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_len_nxt   = r_len;
        w_reps_nxt  = r_reps;
        w_idx_nxt   = r_idx;
        w_par_nxt   = r_par;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pat_nxt   = pattern;
                    w_len_nxt   = w_len_clamp;
                    w_reps_nxt  = reps;
                    w_idx_nxt   = w_len_clamp - LENW'(1);
                    w_par_nxt   = 1'b0;
                    w_state_nxt = (w_len_clamp == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                w_par_nxt = r_par ^ w_cur_bit;
                if (r_idx == '0) begin
`ifdef XS_TX_PARITY_EN
                    w_state_nxt = S_PAR;
`else
                    w_state_nxt = (r_reps != '0) ? S_GAP : S_DONE;
`endif
                end else begin
                    w_idx_nxt = r_idx - LENW'(1);
                end
            end
`ifdef XS_TX_PARITY_EN
            S_PAR: begin
                w_state_nxt = (r_reps != '0) ? S_GAP : S_DONE;
            end
`endif
            S_GAP: begin
                w_reps_nxt  = r_reps - REPW'(1);
                w_idx_nxt   = r_len - LENW'(1);
                w_par_nxt   = 1'b0;
                w_state_nxt = S_SEND;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so outputs are pure flops.
    always_comb begin
        w_xs_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_SEND: begin
                w_xs_nxt   = w_nxt_sh[0];
                w_busy_nxt = 1'b1;
            end
`ifdef XS_TX_PARITY_EN
            S_PAR: begin
                w_xs_nxt   = w_par_nxt;
                w_busy_nxt = 1'b1;
            end
`endif
            S_GAP:   w_busy_nxt = 1'b1;
            S_DONE:  w_done_nxt = 1'b1;
            default: w_done_nxt = 1'b0;
        endcase
    end

    // State, latched request and registered outputs; reset wins over any transmission.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_reps  <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_xs    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_len   <= w_len_nxt;
            r_reps  <= w_reps_nxt;
            r_idx   <= w_idx_nxt;
            r_par   <= w_par_nxt;
            r_xs    <= w_xs_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign xs   = r_xs;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_xs_seq_tx.sv
module tb_xs_seq_tx;
    localparam int W    = 8;
    localparam int LENW = 4;
    localparam int REPW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [W-1:0]    pattern;
    logic [LENW-1:0] len;
    logic [REPW-1:0] reps;
    logic            xs;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    xs_seq_tx #(.W(W), .LENW(LENW), .REPW(REPW)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .len(len), .reps(reps), .xs(xs), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic xs;
        logic busy;
        logic done;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    // Monitor: every falling edge, compare the DUT outputs with the oldest queued expectation.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if ({xs, busy, done} !== e) begin
                errors++;
                $display("FAIL %s: xs/busy/done got %b%b%b expected %b%b%b",
                         n, xs, busy, done, e.xs, e.busy, e.done);
            end
        end
    end

    // Queue the expectation for the cycle in progress, then advance one cycle.
    task automatic cyc(input string n, input logic x, input logic b, input logic d);
        exp_t e;
        e.xs = x; e.busy = b; e.done = d;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    // One transmission: start cycle, nb busy cycles with hand-given xs bits (MSB = first), done, idle.
    // smask bit k drives start during busy cycle k together with junk request fields.
    task automatic tx(input string n, input logic [W-1:0] p, input logic [LENW-1:0] l,
                      input logic [REPW-1:0] r, input logic [31:0] smask,
                      input logic [31:0] bits, input int nb,
                      input logic [31:0] pbits, input int pnb);
        logic [31:0] eb;
        int          en;
`ifdef XS_TX_PARITY_EN
        eb = pbits; en = pnb;
`else
        eb = bits;  en = nb;
`endif
        start = 1'b1; pattern = p; len = l; reps = r;
        cyc({n, "/start"}, 1'b0, 1'b0, 1'b0);
        start = 1'b0; pattern = ~p; len = 4'd1; reps = 3'd5;
        for (int k = 1; k <= en; k++) begin
            start = smask[k];
            if (smask[k]) begin
                pattern = 8'h00; len = 4'd1; reps = 3'd0;
            end
            cyc($sformatf("%s/bit%0d", n, k), eb[en-k], 1'b1, 1'b0);
        end
        start = 1'b0;
        cyc({n, "/done"}, 1'b0, 1'b0, 1'b1);
        cyc({n, "/idle"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0;
        @(posedge clk);
        #1;
        cyc("reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc("idle0", 1'b0, 1'b0, 1'b0);

        // Full 8-bit pattern, single send.
        tx("b2", 8'b1011_0010, 4'd8, 3'd0, 32'h0,
           32'b1011_0010, 8, 32'b1_0110_0100, 9);

        // len=3, two extra repetitions, junk upper bits, start pulses in cycles 2..6.
        tx("rep3", 8'b1111_1101, 4'd3, 3'd2, 32'h7C,
           32'b101_0_101_0_101, 11, 32'b1010_0_1010_0_1010, 14);

        // Reset in cycle 4 of an 8-bit send.
        start = 1'b1; pattern = 8'b1011_0010; len = 4'd8; reps = 3'd0;
        cyc("rst/start", 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("rst/bit1", 1'b1, 1'b1, 1'b0);
        cyc("rst/bit2", 1'b0, 1'b1, 1'b0);
        cyc("rst/bit3", 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        cyc("rst/bit4", 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        cyc("rst/after", 1'b0, 1'b0, 1'b0);
        cyc("rst/idle", 1'b0, 1'b0, 1'b0);
        tx("postrst", 8'b0101_1100, 4'd8, 3'd0, 32'h0,
           32'b0101_1100, 8, 32'b0_1011_1000, 9);

        // len=0: done directly, busy never rises.
        tx("len0", 8'hFF, 4'd0, 3'd3, 32'h0, 32'h0, 0, 32'h0, 0);

        // len above W clamps to the full width, MSB first.
        tx("len12", 8'b1001_0110, 4'd12, 3'd0, 32'h0,
           32'b1001_0110, 8, 32'b1_0010_1100, 9);

        // Parity cases (parity bit appended only with the option).
        tx("p101", 8'b0000_0101, 4'd3, 3'd0, 32'h0, 32'b101, 3, 32'b1010, 4);
        tx("p100", 8'b0000_0100, 4'd3, 3'd0, 32'h0, 32'b100, 3, 32'b1001, 4);

        // Back-to-back: start in the done cycle is dropped, start one cycle later is accepted.
        start = 1'b1; pattern = 8'b0000_0010; len = 4'd2; reps = 3'd0;
        cyc("b2b/start", 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("b2b/bit1", 1'b1, 1'b1, 1'b0);
        cyc("b2b/bit2", 1'b0, 1'b1, 1'b0);
`ifdef XS_TX_PARITY_EN
        cyc("b2b/par", 1'b1, 1'b1, 1'b0);
`endif
        start = 1'b1; pattern = 8'b0000_0011;
        cyc("b2b/done", 1'b0, 1'b0, 1'b1);
        start = 1'b1; pattern = 8'b0000_0001;
        cyc("b2b/idle", 1'b0, 1'b0, 1'b0);
        start = 1'b0; pattern = 8'b0000_0011;
        cyc("b2b/nbit1", 1'b0, 1'b1, 1'b0);
        cyc("b2b/nbit2", 1'b1, 1'b1, 1'b0);
`ifdef XS_TX_PARITY_EN
        cyc("b2b/npar", 1'b1, 1'b1, 1'b0);
`endif
        cyc("b2b/ndone", 1'b0, 1'b0, 1'b1);
        cyc("b2b/nidle", 1'b0, 1'b0, 1'b0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xs_seq_tx.md
# xs_seq_tx

Serial pattern transmitter that drives the single-bit `xs` line consumed by the `SD` digital system. A parallel pattern is latched on a start pulse and shifted out MSB-first, one bit per clock. The pattern can be repeated with a one-cycle gap between repetitions. Busy and done flags let a controller or testbench sequence successive transmissions without hand-toggling `xs`.

## Interface
Parameters:
- `W`, 8: maximum pattern width in bits.
- `LENW`, 4: width of the `len` port. It must satisfy 2^LENW > W.
- `REPW`, 3: width of the `reps` port.

Ports:
- Clock and reset: one clock (`clk`); reset (`reset`) is synchronous and active-high.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `start`  in  1  request; sampled only in IDLE.
- `pattern`  in  W  bits to send; bit `len-1` is sent first, bit 0 last.
- `len`  in  LENW  number of bits per repetition; values above W clamp to W.
- `reps`  in  REPW  additional repetitions; total sends = `reps`+1.
- `xs`  out  1  serial output (registered).
- `busy`  out  1  high while a transmission is in progress (registered).
- `done`  out  1  one-cycle pulse when the transmission completes (registered).

## Operation
- States:
  - IDLE: `xs`=0, `busy`=0. On `start`, latch `pattern`, clamped `len`, `reps`, and set the bit index to len-1. Go to SEND, or DONE if len=0.
  - SEND: `xs` = latched bit[idx]. When idx reaches 0, go to PAR if the macro is defined. Otherwise go to GAP if repetitions remain, else DONE.
  - PAR: only with the macro. `xs` = even parity, i.e. the XOR of the `len` bits just sent. Then go to GAP or DONE.
  - GAP: `xs`=0 for one cycle. Decrement the repetition counter, reload idx to len-1, then go to SEND.
  - DONE: `xs`=0, `busy`=0, `done`=1 for this cycle only. Then go to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor allowed to alter the latched values.
- `pattern`, `len` and `reps` may change freely after the start cycle.
- Bits above `len-1` in `pattern` are never transmitted.
- `len`=0: no data bits and no parity bit are sent, and repetitions are skipped. DONE follows IDLE directly.
- `reset` has priority over everything, including mid-transmission. The next state is IDLE, with `xs`=0, `busy`=0, `done`=0 and all counters cleared.

## Timing
- Reset value of every output is 0: `xs`, `busy` and `done`.
- Edge E0 samples `start`=1 in IDLE. After E0, `busy`=1 and `xs`=pattern[len-1].
- Without the macro:
  - Bit k (0-based in send order) is on `xs` during the cycle following edge E(k).
  - Each repetition occupies len cycles; each gap occupies 1 cycle.
  - `done` is high during cycle E0 + (reps+1)·len + reps + 1. `busy` is low in that same cycle.
- With the macro, each repetition lasts len+1 cycles.
- A new `start` is accepted no earlier than the edge that ends the `done` cycle. The minimum spacing between transmissions is therefore one idle cycle after `done`.
- `len`=0: `done` is high in the cycle after E0, and `busy` never rises.

## Configuration
- `XS_TX_PARITY_EN` defined:
  - The PAR state exists and appends one even-parity bit after every repetition.
  - Total duration is (reps+1)·(len+1) + reps cycles before `done`.
- Not defined:
  - The PAR state is absent and no parity bit is sent.
  - Timing is as stated above.

## Test plan
- W=8, `pattern`=8'b1011_0010, `len`=8, `reps`=0, one-cycle `start` → `xs` = 1,0,1,1,0,0,1,0 over cycles 1–8. `busy`=1 over cycles 1–8. `done`=1 only in cycle 9, with `xs`=0.
- `pattern`=8'bxxxx_x101, `len`=3, `reps`=2 → `xs` = 1,0,1,0,1,0,1,0,1,0,1. `done` is in cycle 12. `start` pulses in cycles 2–6 have no effect.
- `reset`=1 during cycle 4 of an 8-bit send → the next cycle has `xs`=0, `busy`=0, `done`=0. A fresh `start` 2 cycles later transmits the full new pattern correctly.
- `len`=0 with `start` → `done` is in cycle 1, while `xs` and `busy` stay 0. `len`=12 with W=8 → exactly 8 bits are sent, starting with pattern[7].
- `XS_TX_PARITY_EN` defined:
  - `pattern`=3'b101, `len`=3 → `xs` = 1,0,1,0 (parity 0), `done` in cycle 5.
  - `pattern`=3'b100 → `xs` = 1,0,0,1.
- Back-to-back: assert `start` in the `done` cycle, then again one cycle later. The first request is ignored and the second is accepted, with the first new bit appearing 2 cycles after `done`.
